// File: rtl/ps2_key_event_pkg.sv
// Shared scancode constants, FSM states and event word layout
// for the PS/2 key event assembler.
package ps2_key_event_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;
    localparam logic [7:0] SC_BATF   = 8'hFC;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    // Pause sends E1 followed by seven more bytes.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef logic [7:0] sc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } state_t;

    // 10-bit event word {ext, brk, code}
    typedef struct packed {
        logic ext;
        logic brk;
        sc_t  code;
    } ev_t;

    // Keyboard status/reply bytes that carry no key information.
    function automatic logic is_ignored(input sc_t b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_BATF) || (b == SC_RESEND);
    endfunction

    function automatic logic is_err(input sc_t b);
        return (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Event stream handshake bundle.
// master: event producer; slave: event consumer.
interface ps2_key_event_if;
    import ps2_key_event_pkg::*;

    logic ev_valid;
    logic ev_ready;
    sc_t  ev_code;
    logic ev_ext;
    logic ev_break;

    modport master (
        output ev_valid, ev_code, ev_ext, ev_break,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_break,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_event_sync_fifo.sv
// Generic first-word-fall-through FIFO with a registered head.
// Ports: push/din, pop, dout (head), empty, full, count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = head_q;
    assign count   = count_q;

    always_comb begin
        rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
        head_d  = mem_q[rptr_d];
        // Writing the slot that becomes head: forward the new word.
        if (do_push && (wptr_q == rptr_d))
            head_d = din;
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= wptr_q + AW'(1);
            end
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end
endmodule

// File: rtl/ps2_key_event.sv
// Assembles PS/2 prefix sequences (E0/F0/E1) into make/break events
// and queues them. Ports: clk, reset (async low), byte_valid/byte_data/
// parity_err in, ev (event handshake), ev_count, overflow/ovf_clear,
// proto_err pulse.
module ps2_key_event
    import ps2_key_event_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000,
    parameter int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid,
    input  sc_t              byte_data,
    input  logic             parity_err,
    ps2_key_event_if.master  ev,
    output logic [CW-1:0]    ev_count,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic             proto_err
);
    localparam int TW = $clog2(TIMEOUT);

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop, full, empty, good;
    ev_t           word, head;
    logic [9:0]    dout;

    assign good = byte_valid && !parity_err;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        perr_d  = 1'b0;
        push    = 1'b0;
        word    = '0;

        // Prefix watchdog: any byte restarts it, idle never counts.
        if (byte_valid)
            tmo_d = '0;
        else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                perr_d  = 1'b1;
                tmo_d   = '0;
            end else
                tmo_d = tmo_q + TW'(1);
        end

        if (byte_valid && parity_err) begin
            state_d = ST_IDLE;
            perr_d  = 1'b1;
        end else if (good && is_err(byte_data)) begin
            state_d = ST_IDLE;
            perr_d  = 1'b1;
        end else if (good) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        (byte_data == SC_E0): state_d = ST_E0;
                        (byte_data == SC_F0): state_d = ST_F0;
                        (byte_data == SC_E1): begin
                            state_d = ST_PAUSE;
                            skip_d  = PAUSE_SKIP;
                        end
                        is_ignored(byte_data): ;
                        default: begin
                            push = 1'b1;
                            word = '{1'b0, 1'b0, byte_data};
                        end
                    endcase
                end
                ST_E0: begin
                    unique case (1'b1)
                        (byte_data == SC_F0): state_d = ST_E0F0;
                        (byte_data == SC_E0): ;
                        default: begin
                            push    = 1'b1;
                            word    = '{1'b1, 1'b0, byte_data};
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_F0: begin
                    push    = 1'b1;
                    word    = '{1'b0, 1'b1, byte_data};
                    state_d = ST_IDLE;
                end
                ST_E0F0: begin
                    push    = 1'b1;
                    word    = '{1'b1, 1'b1, byte_data};
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        push    = 1'b1;
                        word    = '{1'b0, 1'b0, SC_E1};
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (ovf_clear)
            ovf_d = 1'b0;
        if (drop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pop  = !empty && ev.ev_ready;
    assign drop = push && full && !pop;

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (ev_count)
    );

    assign head        = ev_t'(dout);
    assign ev.ev_valid = !empty;
    assign ev.ev_code  = head.code;
    assign ev.ev_ext   = head.ext;
    assign ev.ev_break = head.brk;
    assign overflow    = ovf_q;
    assign proto_err   = perr_q;
endmodule
